// File: rtl/ddr3_wr_packer_pkg.sv
// Shared types and constants for the DDR3 write packer.
package ddr3_wr_packer_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;

  localparam logic [2:0] DDR3_CMD_WRITE = 3'b000;
  localparam int         BEAT_WORDS     = 4;
  localparam int         BEAT_WIDTH     = 128;
endpackage

// File: rtl/beat_queue.sv
// Power-of-two circular beat buffer with occupancy count; head is a combinational read.
module beat_queue #(
  parameter int QDEPTH = 4,
  parameter int WIDTH  = 128,
  parameter int PW     = $clog2(QDEPTH)
) (
  input  logic             clk_pcie,
  input  logic             data_path_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [PW:0]      count
);
  logic [WIDTH-1:0] mem [QDEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;

  always_ff @(posedge clk_pcie) begin
    if (data_path_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_pcie) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/ddr3_wr_packer.sv
// Packs 32-bit capture words into 128-bit beats and writes them to the DDR3 native
// app interface at wrapping sequential addresses, with back-pressure to the data path.
module ddr3_wr_packer
  import ddr3_wr_packer_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 28'h0000000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = 28'h8000000,
  parameter int                    ADDR_STEP  = 8,
  parameter int                    QDEPTH     = 4
) (
  input  logic                  clk_pcie,
  input  logic                  data_path_rst,
  input  logic [31:0]           din32,
  input  logic                  din_valid,
  input  logic                  flush,
  output logic                  ddr3_fifo_full,
  output logic [ADDR_WIDTH-1:0] app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [127:0]          app_wdf_data,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  output logic [15:0]           app_wdf_mask,
  input  logic                  app_wdf_rdy,
  output logic [31:0]           beat_cnt,
  output logic [15:0]           wrap_cnt,
  output logic                  busy
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(QDEPTH - 1);

  // packer
  logic [BEAT_WORDS-1:0][31:0] words, words_nxt;
  logic [1:0]                  widx, widx_nxt, widx_d;
  logic                        q_push, q_pop;
  logic [CW-1:0]               q_count, cnt_nxt;
  logic [BEAT_WIDTH-1:0]       q_head;

  always_comb begin
    words_nxt = words;
    if (din_valid) words_nxt[widx] = din32;
    widx_nxt = widx + {1'b0, din_valid};
    // widx_nxt wraps to 0 on a 4th word, so a coincident flush adds no second beat
    q_push   = (din_valid && widx == 2'd3) || (flush && widx_nxt != 2'd0);
    widx_d   = q_push ? 2'd0 : widx_nxt;
  end

  beat_queue #(.QDEPTH(QDEPTH), .WIDTH(BEAT_WIDTH)) u_queue (
    .clk_pcie      (clk_pcie),
    .data_path_rst (data_path_rst),
    .push          (q_push),
    .push_data     (words_nxt),
    .pop           (q_pop),
    .head          (q_head),
    .count         (q_count)
  );

  // issue FSM
  state_t state, state_d;
  logic   cmd_ok, dat_ok, cmd_ok_d, dat_ok_d, en_d, wren_d;
  logic   cmd_done, dat_done, beat_done, busy_d;

  assign cmd_done = cmd_ok | (app_en & app_rdy);
  assign dat_done = dat_ok | (app_wdf_wren & app_wdf_rdy);
  assign q_pop    = beat_done;

  always_comb begin
    state_d   = state;
    cmd_ok_d  = cmd_ok;
    dat_ok_d  = dat_ok;
    en_d      = app_en;
    wren_d    = app_wdf_wren;
    beat_done = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (q_count != '0) begin
          state_d = ST_ISSUE;
          en_d    = 1'b1;
          wren_d  = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (cmd_done && dat_done) begin
          beat_done = 1'b1;
          cmd_ok_d  = 1'b0;
          dat_ok_d  = 1'b0;
          if (q_count > CW'(1) || q_push) begin
            en_d   = 1'b1;
            wren_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
            wren_d  = 1'b0;
          end
        end else begin
          cmd_ok_d = cmd_done;
          dat_ok_d = dat_done;
          en_d     = ~cmd_done;
          wren_d   = ~dat_done;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt = q_count;
    case ({q_push, q_pop})
      2'b10:   cnt_nxt = q_count + 1'b1;
      2'b01:   cnt_nxt = q_count - 1'b1;
      default: ;
    endcase
    busy_d = (cnt_nxt != '0) || (widx_d != 2'd0) || (state_d == ST_ISSUE);
  end

  // one extra bit so a limit near the top of the address space cannot overflow
  logic [ADDR_WIDTH:0] addr_sum;
  logic                addr_wrap;
  assign addr_sum  = {1'b0, app_addr} + (ADDR_WIDTH+1)'(ADDR_STEP);
  assign addr_wrap = addr_sum >= {1'b0, ADDR_LIMIT};

  always_ff @(posedge clk_pcie) begin
    if (data_path_rst) begin
      words          <= '0;
      widx           <= 2'd0;
      state          <= ST_IDLE;
      cmd_ok         <= 1'b0;
      dat_ok         <= 1'b0;
      app_en         <= 1'b0;
      app_wdf_wren   <= 1'b0;
      busy           <= 1'b0;
      ddr3_fifo_full <= 1'b0;
      app_addr       <= BASE_ADDR;
      beat_cnt       <= '0;
      wrap_cnt       <= '0;
    end else begin
      words          <= q_push ? '0 : words_nxt;
      widx           <= widx_d;
      state          <= state_d;
      cmd_ok         <= cmd_ok_d;
      dat_ok         <= dat_ok_d;
      app_en         <= en_d;
      app_wdf_wren   <= wren_d;
      busy           <= busy_d;
      ddr3_fifo_full <= q_count >= FULL_LVL;
      if (beat_done) begin
        beat_cnt <= beat_cnt + 32'd1;
        if (addr_wrap) begin
          app_addr <= BASE_ADDR;
          if (wrap_cnt != 16'hFFFF) wrap_cnt <= wrap_cnt + 16'd1;
        end else begin
          app_addr <= addr_sum[ADDR_WIDTH-1:0];
        end
      end
    end
  end

  assign app_cmd      = DDR3_CMD_WRITE;
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_mask = '0;
  assign app_wdf_data = q_head;
endmodule

// File: tb/tb_ddr3_wr_packer.sv
// Scoreboard bench for ddr3_wr_packer: expected beats/addresses queued at stimulus time,
// compared at each DDR3 handshake.
module tb_ddr3_wr_packer;
  localparam int          AW     = 28;
  localparam logic [27:0] BASE   = 28'h0;
  localparam logic [27:0] LIMIT  = 28'h20;
  localparam int          QDEPTH = 4;

  logic          clk_pcie = 1'b0;
  logic          data_path_rst = 1'b1;
  logic [31:0]   din32 = '0;
  logic          din_valid = 1'b0;
  logic          flush = 1'b0;
  logic          ddr3_fifo_full;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic          app_rdy = 1'b0;
  logic [127:0]  app_wdf_data;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic [15:0]   app_wdf_mask;
  logic          app_wdf_rdy = 1'b0;
  logic [31:0]   beat_cnt;
  logic [15:0]   wrap_cnt;
  logic          busy;

  ddr3_wr_packer #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .ADDR_LIMIT(LIMIT),
                   .ADDR_STEP(8), .QDEPTH(QDEPTH)) dut (
    .clk_pcie(clk_pcie), .data_path_rst(data_path_rst), .din32(din32),
    .din_valid(din_valid), .flush(flush), .ddr3_fifo_full(ddr3_fifo_full),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy), .beat_cnt(beat_cnt),
    .wrap_cnt(wrap_cnt), .busy(busy)
  );

  always #5 clk_pcie = ~clk_pcie;

  int checks = 0, failures = 0;
  logic [127:0] exp_data_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [127:0] cur = '0;
  int widx_m = 0;
  logic [AW-1:0] m_addr = BASE;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void push_exp(input logic [127:0] d);
    exp_data_q.push_back(d);
    exp_addr_q.push_back(m_addr);
    m_addr = ({1'b0, m_addr} + 29'd8 >= {1'b0, LIMIT}) ? BASE : m_addr + 28'd8;
  endfunction

  function automatic void model_flush();
    if (widx_m != 0) begin
      push_exp(cur);
      cur = '0;
      widx_m = 0;
    end
  endfunction

  // data-path model: rd_en gated by ddr3_fifo_full, din_valid one cycle later
  task automatic send_words(input int n, input logic [31:0] first, input bit flush_last);
    int issued = 0, got = 0, guard = 0;
    bit rd = 0;
    while (got < n && guard < 3000) begin
      @(negedge clk_pcie);
      din_valid = rd;
      flush = 1'b0;
      if (rd) begin
        din32 = first + got;
        cur[widx_m*32 +: 32] = din32;
        widx_m++;
        got++;
        if (widx_m == 4) begin
          push_exp(cur);
          cur = '0;
          widx_m = 0;
        end
        if (flush_last && got == n) begin
          flush = 1'b1;
          model_flush();
        end
      end else din32 = '0;
      rd = (issued < n) && !ddr3_fifo_full;
      if (rd) issued++;
      guard++;
    end
    chk("send_done", got, n);
    @(negedge clk_pcie);
    din_valid = 1'b0; din32 = '0; flush = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk_pcie);
    flush = 1'b1;
    model_flush();
    @(negedge clk_pcie);
    flush = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_pcie);
    data_path_rst = 1'b1; din_valid = 1'b0; flush = 1'b0;
    @(negedge clk_pcie);
    chk("rst_app_en", app_en, 0);
    chk("rst_wren", app_wdf_wren, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", app_addr, BASE);
    chk("rst_full", ddr3_fifo_full, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_wrap_cnt", wrap_cnt, 0);
    data_path_rst = 1'b0;
    exp_data_q.delete(); exp_addr_q.delete();
    cur = '0; widx_m = 0; m_addr = BASE;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk_pcie);
      n++;
    end while ((busy || exp_data_q.size() != 0) && n < 500);
    chk("idle_busy", busy, 0);
    chk("sb_drained", exp_data_q.size() + exp_addr_q.size(), 0);
  endtask

  task automatic wait_app_en();
    int n = 0;
    while (!app_en && n < 100) begin
      @(negedge clk_pcie);
      n++;
    end
    chk("app_en_seen", app_en, 1);
  endtask

  // handshake monitor, sampled mid-low-phase after the drivers settle
  always begin
    @(negedge clk_pcie);
    #1;
    if (!data_path_rst) begin
      if (app_en && app_rdy) begin
        if (exp_addr_q.size() == 0) chk("cmd_unexpected", 1, 0);
        else chk("app_addr", app_addr, exp_addr_q.pop_front());
        chk("app_cmd", app_cmd, 0);
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        if (exp_data_q.size() == 0) chk("data_unexpected", 1, 0);
        else chk("app_wdf_data", app_wdf_data, exp_data_q.pop_front());
        chk("wdf_end", app_wdf_end, 1);
        chk("wdf_mask", app_wdf_mask, 0);
      end
      if (dut.q_push && dut.q_count == 3'(QDEPTH)) chk("q_overflow", 1, 0);
    end
  end

  initial begin
    repeat (2) @(negedge clk_pcie);
    do_reset();

    // two full beats, free-flowing interface
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    send_words(8, 32'h1, 1'b0);
    wait_idle();
    chk("two_beats_cnt", beat_cnt, 2);
    chk("two_beats_addr", app_addr, 28'h10);

    // partial flush, empty flush, flush on the 4th word
    do_reset();
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    send_words(3, 32'hA, 1'b0);
    pulse_flush();
    wait_idle();
    chk("flush_partial_cnt", beat_cnt, 1);
    pulse_flush();
    wait_idle();
    chk("flush_empty_cnt", beat_cnt, 1);
    send_words(4, 32'h20, 1'b1);
    wait_idle();
    chk("flush_on_4th_cnt", beat_cnt, 2);

    // stalled interface fills the queue, then drains in order
    do_reset();
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    fork
      send_words(16, 32'h200, 1'b0);
      begin
        repeat (80) @(negedge clk_pcie);
        chk("stall_full", ddr3_fifo_full, 1);
        chk("stall_beat_cnt", beat_cnt, 0);
        chk("stall_app_en", app_en, 1);
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      end
    join
    wait_idle();
    chk("stall_drain_cnt", beat_cnt, 4);
    chk("stall_full_clear", ddr3_fifo_full, 0);

    // split handshake: command accepted 3 cycles before data
    do_reset();
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    send_words(4, 32'h100, 1'b0);
    wait_app_en();
    app_rdy = 1'b1;
    @(negedge clk_pcie);
    app_rdy = 1'b0;
    chk("split_en_drop", app_en, 0);
    chk("split_wren_hold", app_wdf_wren, 1);
    repeat (2) @(negedge clk_pcie);
    chk("split_addr_hold", app_addr, 0);
    chk("split_cnt_hold", beat_cnt, 0);
    app_wdf_rdy = 1'b1;
    @(negedge clk_pcie);
    app_wdf_rdy = 1'b0;
    chk("split_cnt", beat_cnt, 1);
    chk("split_addr_step", app_addr, 28'h8);
    chk("split_wren_drop", app_wdf_wren, 0);
    chk("split_busy", busy, 0);

    // address wrap at LIMIT
    do_reset();
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    send_words(20, 32'h300, 1'b0);
    wait_idle();
    chk("wrap_beat_cnt", beat_cnt, 5);
    chk("wrap_cnt", wrap_cnt, 1);
    chk("wrap_addr", app_addr, 28'h8);

    // reset while issuing with two beats queued
    do_reset();
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    send_words(8, 32'h400, 1'b0);
    wait_app_en();
    chk("mid_q_count", dut.q_count, 2);
    do_reset();
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    send_words(4, 32'h500, 1'b0);
    wait_idle();
    chk("post_rst_cnt", beat_cnt, 1);
    chk("post_rst_addr", app_addr, 28'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
